// File: rtl/sram_bridge_pkg.sv
// Shared types and constants for the SRAM bus bridge: FSM state encoding,
// macro data/mask widths and the bank-field extraction helper.
package sram_bridge_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_t;

  localparam int SRAM_DW = 32;
  localparam int SRAM_MW = 4;

  // Bank field sits directly above the word field; byte offset is dropped.
  function automatic int unsigned bank_of(input logic [31:0] addr,
                                          input int unsigned aw,
                                          input int unsigned bw);
    logic [31:0] shifted;
    logic [31:0] field_mask;
    shifted    = addr >> (aw + 32'd2);
    field_mask = (32'd1 << bw) - 32'd1;
    return shifted & field_mask;
  endfunction

endpackage

// File: rtl/sram_bus_bridge.sv
// Valid/ready bus to multi-bank SRAM strobe bridge. One access per two
// cycles: strobes in the request cycle, ready plus read data in the next.
module sram_bus_bridge
  import sram_bridge_pkg::*;
#(
  parameter int BANK_NUM = 4,
  parameter int SRAM_AW  = 10
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic                        mem_valid_i,
  input  logic [31:0]                 mem_addr_i,
  input  logic [31:0]                 mem_wdata_i,
  input  logic [3:0]                  mem_wstrb_i,
  output logic                        mem_ready_o,
  output logic [31:0]                 mem_rdata_o,
  output logic [BANK_NUM-1:0]         sram_cs_o,
  output logic [SRAM_AW-1:0]          sram_addr_o,
  output logic [SRAM_DW-1:0]          sram_data_o,
  output logic [SRAM_MW-1:0]          sram_mask_o,
  output logic                        sram_wren_o,
  input  logic [BANK_NUM*SRAM_DW-1:0] sram_data_i
);

  localparam int BW = (BANK_NUM > 1) ? $clog2(BANK_NUM) : 1;

  state_t            state;
  logic [BW-1:0]     bank_q;
  logic              bank_ok_q;
  logic              wr_q;

  int unsigned       bank_idx;
  logic [BW-1:0]     bank_w;
  logic              bank_ok;
  logic              access;
  logic              is_write;
  logic [SRAM_DW-1:0] rdata_mux;

  always_comb begin
    bank_idx = bank_of(mem_addr_i, unsigned'(SRAM_AW), unsigned'(BW));
    bank_w   = bank_idx[BW-1:0];
    bank_ok  = (bank_idx < unsigned'(BANK_NUM));
  end

  // Reset and state gate the request so no strobe leaks out during ACK or reset.
  assign access   = rst_n_i && (state == IDLE) && mem_valid_i;
  assign is_write = |mem_wstrb_i;

  always_comb begin
    sram_cs_o = '0;
    for (int k = 0; k < BANK_NUM; k++) begin
      sram_cs_o[k] = access && bank_ok && (bank_w == BW'(k));
    end
  end

  assign sram_wren_o = access && is_write;
  assign sram_mask_o = access ? mem_wstrb_i : '0;
  assign sram_addr_o = mem_addr_i[SRAM_AW+1:2];
  assign sram_data_o = mem_wdata_i;

  always_comb begin
    rdata_mux = '0;
    for (int k = 0; k < BANK_NUM; k++) begin
      if (bank_q == BW'(k)) begin
        rdata_mux = sram_data_i[k*SRAM_DW +: SRAM_DW];
      end
    end
  end

  assign mem_ready_o = rst_n_i && (state == ACK);
  assign mem_rdata_o = (mem_ready_o && !wr_q && bank_ok_q) ? rdata_mux : '0;

  // ACK always returns to IDLE so the master's next request is re-evaluated there.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= IDLE;
      bank_q    <= '0;
      bank_ok_q <= 1'b0;
      wr_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_valid_i) begin
            state     <= ACK;
            bank_q    <= bank_w;
            bank_ok_q <= bank_ok;
            wr_q      <= is_write;
          end
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
